obuf_wr_arbiter: RTL and testbench

- Round-robin write arbiter in front of the output-buffer FIFO. It is shared by the three PE-row result ports p0/p1/p2.
- Each requester gets a one-entry holding slot. The block then presents at most one one-hot write strobe per cycle to the FIFO, so a simultaneous-write error can never occur.
- It honours FIFO full and counts writes per output channel, pulsing frame_done after each complete 3x3 channel.

---
 rtl/obuf_wr_arbiter.sv | 138 +++++++++++++
 tb/tb_obuf_wr_arbiter.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/obuf_wr_arbiter.sv
// Round-robin write arbiter for the output-buffer FIFO: three one-entry holding
// slots, one-hot write strobe, per-channel write counter with frame_done pulse.

module obuf_wr_slot #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr_i,
  input  logic         acc_i,
  input  logic         gnt_i,
  input  logic [W-1:0] data_i,
  output logic         vld_o,
  output logic [W-1:0] data_o
);
  logic         vld_q;
  logic [W-1:0] data_q;

  // A same-cycle accept wins over the drain, so the slot refills without a bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q  <= 1'b0;
      data_q <= '0;
    end else if (clr_i) begin
      vld_q  <= 1'b0;
    end else if (acc_i) begin
      vld_q  <= 1'b1;
      data_q <= data_i;
    end else if (gnt_i) begin
      vld_q  <= 1'b0;
    end
  end

  assign vld_o  = vld_q;
  assign data_o = data_q;
endmodule

module obuf_wr_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int FRAME_LEN  = 9,
  parameter int CNT_WIDTH  = 4
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                clr_i,
  input  logic [2:0]                          req_valid_i,
  input  logic [2:0][2*DATA_WIDTH-1:0]        req_data_i,
  output logic [2:0]                          req_ready_o,
  input  logic                                ob_full_i,
  output logic [2:0]                          ob_sel_o,
  output logic [2*DATA_WIDTH-1:0]             ob_data_o,
  output logic                                frame_done_o,
  output logic [CNT_WIDTH-1:0]                wr_cnt_o
);
  localparam int DW = 2*DATA_WIDTH;

  logic [2:0]          slot_vld;
  logic [2:0][DW-1:0]  slot_data;
  logic [2:0]          gnt;
  logic [2:0]          acc;
  logic [1:0]          rr_ptr_q, rr_ptr_d;
  logic [CNT_WIDTH-1:0] wr_cnt_q, wr_cnt_d;
  logic                frame_done_q, frame_done_d;

  assign req_ready_o = {3{~clr_i}} & (~slot_vld | gnt);
  assign acc         = req_valid_i & req_ready_o;

  for (genvar i = 0; i < 3; i++) begin : g_slot
    obuf_wr_slot #(.W(DW)) u_slot (
      .clk    (clk),
      .rst_n  (rst_n),
      .clr_i  (clr_i),
      .acc_i  (acc[i]),
      .gnt_i  (gnt[i]),
      .data_i (req_data_i[i]),
      .vld_o  (slot_vld[i]),
      .data_o (slot_data[i])
    );
  end

  // Search order starts at rr_ptr; gnt[i] refers to requester i.
  always_comb begin
    gnt = 3'b000;
    if (!clr_i && !ob_full_i) begin
      case (rr_ptr_q)
        2'd0:    if (slot_vld[0]) gnt = 3'b001; else if (slot_vld[1]) gnt = 3'b010;
                 else if (slot_vld[2]) gnt = 3'b100;
        2'd1:    if (slot_vld[1]) gnt = 3'b010; else if (slot_vld[2]) gnt = 3'b100;
                 else if (slot_vld[0]) gnt = 3'b001;
        default: if (slot_vld[2]) gnt = 3'b100; else if (slot_vld[0]) gnt = 3'b001;
                 else if (slot_vld[1]) gnt = 3'b010;
      endcase
    end
  end

  always_comb begin
    rr_ptr_d     = rr_ptr_q;
    wr_cnt_d     = wr_cnt_q;
    frame_done_d = 1'b0;
    if (clr_i) begin
      rr_ptr_d = 2'd0;
      wr_cnt_d = '0;
    end else if (|gnt) begin
      if (gnt[0])      rr_ptr_d = 2'd1;
      else if (gnt[1]) rr_ptr_d = 2'd2;
      else             rr_ptr_d = 2'd0;
      if (wr_cnt_q == CNT_WIDTH'(FRAME_LEN-1)) begin
        wr_cnt_d     = '0;
        frame_done_d = 1'b1;
      end else begin
        wr_cnt_d = wr_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q     <= 2'd0;
      wr_cnt_q     <= '0;
      frame_done_q <= 1'b0;
    end else begin
      rr_ptr_q     <= rr_ptr_d;
      wr_cnt_q     <= wr_cnt_d;
      frame_done_q <= frame_done_d;
    end
  end

  always_comb begin
    ob_data_o = '0;
    if (gnt[0])      ob_data_o = slot_data[0];
    else if (gnt[1]) ob_data_o = slot_data[1];
    else if (gnt[2]) ob_data_o = slot_data[2];
  end

  assign ob_sel_o     = {gnt[0], gnt[1], gnt[2]};
  assign frame_done_o = frame_done_q;
  assign wr_cnt_o     = wr_cnt_q;
endmodule

// File: tb/tb_obuf_wr_arbiter.sv
// Directed bench for obuf_wr_arbiter: order, streaming/frame wrap, full stall,
// fairness, synchronous clear and asynchronous reset.

module tb_obuf_wr_arbiter;
  logic             clk = 1'b0;
  logic             rst_n;
  logic             clr;
  logic [2:0]       req_valid;
  logic [2:0][15:0] req_data;
  logic [2:0]       req_ready;
  logic             ob_full;
  logic [2:0]       ob_sel;
  logic [15:0]      ob_data;
  logic             frame_done;
  logic [3:0]       wr_cnt;

  int checks = 0;
  int errors = 0;

  obuf_wr_arbiter #(.DATA_WIDTH(8), .FRAME_LEN(9), .CNT_WIDTH(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .clr_i        (clr),
    .req_valid_i  (req_valid),
    .req_data_i   (req_data),
    .req_ready_o  (req_ready),
    .ob_full_i    (ob_full),
    .ob_sel_o     (ob_sel),
    .ob_data_o    (ob_data),
    .frame_done_o (frame_done),
    .wr_cnt_o     (wr_cnt)
  );

  always #5 clk = ~clk;

  // Drive one cycle's inputs at the falling edge, let combinational outputs settle.
  task automatic cyc(input logic [2:0] v, input logic [15:0] d0, input logic [15:0] d1,
                     input logic [15:0] d2, input logic full, input logic c);
    @(negedge clk);
    req_valid = v; req_data[0] = d0; req_data[1] = d1; req_data[2] = d2;
    ob_full = full; clr = c;
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; clr = 1'b0; req_valid = 3'b000; ob_full = 1'b0; req_data = '0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; clr = 1'b0; req_valid = 3'b000; ob_full = 1'b0; req_data = '0;
    #12;
    checks++; if (ob_sel !== 3'b000) begin errors++; $display("FAIL reset_sel got %b exp 000", ob_sel); end
    checks++; if (ob_data !== 16'h0) begin errors++; $display("FAIL reset_data got %h exp 0000", ob_data); end
    checks++; if (req_ready !== 3'b111) begin errors++; $display("FAIL reset_ready got %b exp 111", req_ready); end
    checks++; if (wr_cnt !== 4'd0) begin errors++; $display("FAIL reset_cnt got %0d exp 0", wr_cnt); end
    checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_fd got %b exp 0", frame_done); end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_order();
    logic [2:0]  exp_sel [4] = '{3'b100, 3'b010, 3'b001, 3'b000};
    logic [15:0] exp_dat [4] = '{16'h0101, 16'h0202, 16'h0303, 16'h0000};
    do_reset();
    cyc(3'b111, 16'h0101, 16'h0202, 16'h0303, 1'b0, 1'b0);
    checks++; if (ob_sel !== 3'b000) begin errors++; $display("FAIL order_first got %b exp 000", ob_sel); end
    for (int k = 0; k < 4; k++) begin
      cyc(3'b000, 16'h0, 16'h0, 16'h0, 1'b0, 1'b0);
      checks++; if (ob_sel !== exp_sel[k]) begin errors++; $display("FAIL order_sel[%0d] got %b exp %b", k, ob_sel, exp_sel[k]); end
      checks++; if (ob_data !== exp_dat[k]) begin errors++; $display("FAIL order_data[%0d] got %h exp %h", k, ob_data, exp_dat[k]); end
    end
    checks++; if (wr_cnt !== 4'd3) begin errors++; $display("FAIL order_cnt got %0d exp 3", wr_cnt); end
  endtask

  task automatic test_stream();
    do_reset();
    for (int k = 0; k < 9; k++) begin
      cyc(3'b010, 16'h0, 16'h0010 + 16'(k), 16'h0, 1'b0, 1'b0);
      if (k == 0) begin
        checks++; if (ob_sel !== 3'b000) begin errors++; $display("FAIL stream_sel0 got %b exp 000", ob_sel); end
      end else begin
        checks++; if (ob_sel !== 3'b010) begin errors++; $display("FAIL stream_sel[%0d] got %b exp 010", k, ob_sel); end
        checks++; if (ob_data !== 16'h0010 + 16'(k-1)) begin errors++; $display("FAIL stream_data[%0d] got %h exp %h", k, ob_data, 16'h0010 + 16'(k-1)); end
        checks++; if (wr_cnt !== 4'(k-1)) begin errors++; $display("FAIL stream_cnt[%0d] got %0d exp %0d", k, wr_cnt, k-1); end
        checks++; if (req_ready[1] !== 1'b1) begin errors++; $display("FAIL stream_ready[%0d] got %b exp 1", k, req_ready[1]); end
      end
      checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL stream_fd[%0d] got %b exp 0", k, frame_done); end
    end
    cyc(3'b000, 16'h0, 16'h0, 16'h0, 1'b0, 1'b0);
    checks++; if (ob_data !== 16'h0018 || ob_sel !== 3'b010) begin errors++; $display("FAIL stream_last got %b/%h exp 010/0018", ob_sel, ob_data); end
    checks++; if (wr_cnt !== 4'd8) begin errors++; $display("FAIL stream_cnt8 got %0d exp 8", wr_cnt); end
    cyc(3'b000, 16'h0, 16'h0, 16'h0, 1'b0, 1'b0);
    checks++; if (frame_done !== 1'b1) begin errors++; $display("FAIL stream_fd_pulse got %b exp 1", frame_done); end
    checks++; if (wr_cnt !== 4'd0) begin errors++; $display("FAIL stream_wrap got %0d exp 0", wr_cnt); end
    checks++; if (ob_sel !== 3'b000) begin errors++; $display("FAIL stream_idle got %b exp 000", ob_sel); end
    cyc(3'b000, 16'h0, 16'h0, 16'h0, 1'b0, 1'b0);
    checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL stream_fd_end got %b exp 0", frame_done); end
  endtask

  task automatic test_full();
    logic [2:0]  exp_sel [3] = '{3'b100, 3'b010, 3'b001};
    logic [15:0] exp_dat [3] = '{16'h1111, 16'h2222, 16'h3333};
    do_reset();
    cyc(3'b111, 16'h1111, 16'h2222, 16'h3333, 1'b1, 1'b0);
    checks++; if (req_ready !== 3'b111) begin errors++; $display("FAIL full_empty_ready got %b exp 111", req_ready); end
    for (int k = 0; k < 5; k++) begin
      cyc(3'b111, 16'hDEAD, 16'hDEAD, 16'hDEAD, 1'b1, 1'b0);
      checks++; if (ob_sel !== 3'b000) begin errors++; $display("FAIL full_sel[%0d] got %b exp 000", k, ob_sel); end
      checks++; if (req_ready !== 3'b000) begin errors++; $display("FAIL full_ready[%0d] got %b exp 000", k, req_ready); end
      checks++; if (wr_cnt !== 4'd0) begin errors++; $display("FAIL full_cnt[%0d] got %0d exp 0", k, wr_cnt); end
    end
    for (int k = 0; k < 3; k++) begin
      cyc(3'b000, 16'h0, 16'h0, 16'h0, 1'b0, 1'b0);
      checks++; if (ob_sel !== exp_sel[k]) begin errors++; $display("FAIL full_rel_sel[%0d] got %b exp %b", k, ob_sel, exp_sel[k]); end
      checks++; if (ob_data !== exp_dat[k]) begin errors++; $display("FAIL full_rel_data[%0d] got %h exp %h", k, ob_data, exp_dat[k]); end
    end
  endtask

  task automatic test_fairness();
    logic [2:0] exp_sel [4] = '{3'b100, 3'b001, 3'b100, 3'b001};
    do_reset();
    cyc(3'b101, 16'h00A0, 16'h0, 16'h00C0, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      cyc(3'b101, 16'h00A0, 16'h0, 16'h00C0, 1'b0, 1'b0);
      checks++; if (ob_sel !== exp_sel[k]) begin errors++; $display("FAIL fair_sel[%0d] got %b exp %b", k, ob_sel, exp_sel[k]); end
    end
  endtask

  task automatic test_clr();
    do_reset();
    for (int k = 0; k < 5; k++) cyc(3'b001, 16'h0050 + 16'(k), 16'h0, 16'h0, 1'b0, 1'b0);
    cyc(3'b000, 16'h0, 16'h0, 16'h0, 1'b0, 1'b0);
    cyc(3'b101, 16'hBAD0, 16'h0, 16'hBAD2, 1'b1, 1'b0);
    checks++; if (wr_cnt !== 4'd5) begin errors++; $display("FAIL clr_pre_cnt got %0d exp 5", wr_cnt); end
    cyc(3'b000, 16'h0, 16'h0, 16'h0, 1'b0, 1'b1);
    checks++; if (ob_sel !== 3'b000) begin errors++; $display("FAIL clr_sel got %b exp 000", ob_sel); end
    checks++; if (req_ready !== 3'b000) begin errors++; $display("FAIL clr_ready got %b exp 000", req_ready); end
    cyc(3'b111, 16'h0A0A, 16'h0B0B, 16'h0C0C, 1'b0, 1'b0);
    checks++; if (ob_sel !== 3'b000 || ob_data !== 16'h0) begin errors++; $display("FAIL clr_after got %b/%h exp 000/0000", ob_sel, ob_data); end
    checks++; if (wr_cnt !== 4'd0) begin errors++; $display("FAIL clr_cnt got %0d exp 0", wr_cnt); end
    checks++; if (req_ready !== 3'b111) begin errors++; $display("FAIL clr_ready_after got %b exp 111", req_ready); end
    cyc(3'b000, 16'h0, 16'h0, 16'h0, 1'b0, 1'b0);
    checks++; if (ob_sel !== 3'b100 || ob_data !== 16'h0A0A) begin errors++; $display("FAIL clr_ptr got %b/%h exp 100/0a0a", ob_sel, ob_data); end
  endtask

  task automatic test_async_reset();
    do_reset();
    cyc(3'b111, 16'h0101, 16'h0202, 16'h0303, 1'b0, 1'b0);
    cyc(3'b000, 16'h0, 16'h0, 16'h0, 1'b0, 1'b0);
    cyc(3'b000, 16'h0, 16'h0, 16'h0, 1'b0, 1'b0);
    cyc(3'b000, 16'h0, 16'h0, 16'h0, 1'b0, 1'b0);
    checks++; if (ob_sel !== 3'b001 || wr_cnt !== 4'd2) begin errors++; $display("FAIL arst_pre got %b/%0d exp 001/2", ob_sel, wr_cnt); end
    #1 rst_n = 1'b0;
    #1;
    checks++; if (ob_sel !== 3'b000) begin errors++; $display("FAIL arst_sel got %b exp 000", ob_sel); end
    checks++; if (req_ready !== 3'b111) begin errors++; $display("FAIL arst_ready got %b exp 111", req_ready); end
    checks++; if (wr_cnt !== 4'd0) begin errors++; $display("FAIL arst_cnt got %0d exp 0", wr_cnt); end
    @(negedge clk); rst_n = 1'b1;
    cyc(3'b000, 16'h0, 16'h0, 16'h0, 1'b0, 1'b0);
    checks++; if (ob_sel !== 3'b000) begin errors++; $display("FAIL arst_discard got %b exp 000", ob_sel); end
  endtask

  // Strobe must never carry more than one bit.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      checks++;
      if (!$onehot0(ob_sel)) begin errors++; $display("FAIL onehot got %b", ob_sel); end
    end
  end

  initial begin
    test_reset();
    test_order();
    test_stream();
    test_full();
    test_fairness();
    test_clr();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
